// File: rtl/aes_bist_ctrl.sv
// AES BIST sequencer: clears the pattern generators and MISR, runs N_PATTERNS generator
// cycles, drains the datapath pipeline, then checks the MISR signature against GOLDEN_SIG.
module aes_bist_ctrl #(
  parameter int                N_PATTERNS = 256,
  parameter int                LATENCY    = 4,
  parameter int                SIG_W      = 8,
  parameter logic [SIG_W-1:0]  GOLDEN_SIG = 8'hC0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [SIG_W-1:0] sig_in,
  output logic             bist_rst,
  output logic             en_gen,
  output logic             en_cmp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             fail,
  output logic [SIG_W-1:0] sig_cap
);

  localparam int CW = $clog2(N_PATTERNS + 1);
  localparam int DW = (LATENCY < 1) ? 1 : $clog2(LATENCY + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(N_PATTERNS - 1);
  localparam logic [DW-1:0] DRN_LAST = (LATENCY < 1) ? '0 : DW'(LATENCY - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_RUN,
    S_DRAIN,
    S_CHECK,
    S_DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [DW-1:0]    drn_q, drn_d;
  logic             bist_rst_q, bist_rst_d;
  logic             en_gen_q, en_gen_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             pass_q, pass_d;
  logic             fail_q, fail_d;
  logic [SIG_W-1:0] sig_cap_q, sig_cap_d;
  logic             flush;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    drn_d   = drn_q;
    flush   = abort && (state_q inside {S_CLEAR, S_RUN, S_DRAIN, S_CHECK});

    case (state_q)
      S_IDLE:  if (start) state_d = S_CLEAR;
      S_CLEAR: begin
        state_d = S_RUN;
        cnt_d   = '0;
        drn_d   = '0;
      end
      S_RUN: begin
        if (cnt_q == CNT_LAST) state_d = (LATENCY == 0) ? S_CHECK : S_DRAIN;
        else                   cnt_d   = cnt_q + CW'(1);
      end
      S_DRAIN: begin
        if (drn_q == DRN_LAST) state_d = S_CHECK;
        else                   drn_d   = drn_q + DW'(1);
      end
      S_CHECK: state_d = S_DONE;
      S_DONE:  if (start) state_d = S_CLEAR;
      default: state_d = S_IDLE;
    endcase

    if (flush) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      drn_d   = '0;
    end

    // Outputs are decoded from the next state so they line up with the state register.
    bist_rst_d = (state_d == S_CLEAR);
    en_gen_d   = (state_d == S_RUN);
    busy_d     = (state_d inside {S_CLEAR, S_RUN, S_DRAIN, S_CHECK});
    done_d     = (state_d == S_DONE);
    pass_d     = 1'b0;
    fail_d     = 1'b0;
    sig_cap_d  = '0;
    if (state_d == S_DONE) begin
      if (state_q == S_CHECK) begin
        sig_cap_d = sig_in;
        pass_d    = (sig_in == GOLDEN_SIG);
        fail_d    = (sig_in != GOLDEN_SIG);
      end else begin
        sig_cap_d = sig_cap_q;
        pass_d    = pass_q;
        fail_d    = fail_q;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      drn_q      <= '0;
      bist_rst_q <= 1'b0;
      en_gen_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      sig_cap_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      drn_q      <= drn_d;
      bist_rst_q <= bist_rst_d;
      en_gen_q   <= en_gen_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      sig_cap_q  <= sig_cap_d;
    end
  end

  // en_cmp mirrors en_gen through the datapath latency so the MISR sees matching responses.
  if (LATENCY == 0) begin : g_no_delay
    assign en_cmp = en_gen_q;
  end else begin : g_delay
    logic [LATENCY-1:0] dly_q, dly_d;

    always_comb begin
      dly_d    = dly_q << 1;
      dly_d[0] = en_gen_q;
      if (flush) dly_d = '0;
    end

    always_ff @(posedge clk) begin
      if (rst) dly_q <= '0;
      else     dly_q <= dly_d;
    end

    assign en_cmp = dly_q[LATENCY-1];
  end

  assign bist_rst = bist_rst_q;
  assign en_gen   = en_gen_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign pass     = pass_q;
  assign fail     = fail_q;
  assign sig_cap  = sig_cap_q;

endmodule

// File: tb/tb_aes_bist_ctrl.sv
// Bench for aes_bist_ctrl: two instances (LATENCY=4 and LATENCY=0) share stimulus and are
// compared every cycle against a timeline model, plus directed literal checks.
module tb_aes_bist_ctrl;

  localparam int NP = 16;

  logic clk = 1'b0;
  logic rst, start, abort;
  logic [7:0] sig_in;

  logic [1:0]      d_bist, d_gen, d_cmp, d_busy, d_done, d_pass, d_fail;
  logic [1:0][7:0] d_sig;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 0;

  always #5 clk = ~clk;

  aes_bist_ctrl #(.N_PATTERNS(NP), .LATENCY(4), .SIG_W(8), .GOLDEN_SIG(8'hC0)) dut_l4 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sig_in(sig_in),
    .bist_rst(d_bist[0]), .en_gen(d_gen[0]), .en_cmp(d_cmp[0]), .busy(d_busy[0]),
    .done(d_done[0]), .pass(d_pass[0]), .fail(d_fail[0]), .sig_cap(d_sig[0])
  );

  aes_bist_ctrl #(.N_PATTERNS(NP), .LATENCY(0), .SIG_W(8), .GOLDEN_SIG(8'hC0)) dut_l0 (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .sig_in(sig_in),
    .bist_rst(d_bist[1]), .en_gen(d_gen[1]), .en_cmp(d_cmp[1]), .busy(d_busy[1]),
    .done(d_done[1]), .pass(d_pass[1]), .fail(d_fail[1]), .sig_cap(d_sig[1])
  );

  function automatic int lat_of(input int k);
    return (k == 0) ? 4 : 0;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Timeline model: t counts cycles since the accepting edge (t=1 is CLEAR).
  bit        m_run  [2];
  int        m_t    [2];
  bit        m_done [2];
  bit        m_pass [2];
  bit        m_fail [2];
  logic [7:0] m_sig [2];

  initial begin
    for (int k = 0; k < 2; k++) begin
      m_run[k] = 0; m_t[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_sig[k] = 8'h00;
    end
  end

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_run[k] = 0; m_t[k] = 0; m_done[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_sig[k] = 8'h00;
      end else if (m_run[k]) begin
        if (abort) begin
          m_run[k] = 0;
          m_t[k]   = 0;
        end else if (m_t[k] == NP + lat_of(k) + 2) begin
          m_run[k]  = 0;
          m_done[k] = 1;
          m_sig[k]  = sig_in;
          m_pass[k] = (sig_in == 8'hC0);
          m_fail[k] = (sig_in != 8'hC0);
        end else begin
          m_t[k]++;
        end
      end else if (start) begin
        m_run[k] = 1; m_t[k] = 1; m_done[k] = 0; m_pass[k] = 0; m_fail[k] = 0; m_sig[k] = 8'h00;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int k = 0; k < 2; k++) begin
        bit e_bist, e_gen, e_cmp;
        e_bist = m_run[k] && (m_t[k] == 1);
        e_gen  = m_run[k] && (m_t[k] >= 2) && (m_t[k] <= NP + 1);
        e_cmp  = m_run[k] && (m_t[k] >= 2 + lat_of(k)) && (m_t[k] <= NP + 1 + lat_of(k));
        check($sformatf("m_bist_rst[%0d]", k), 32'(d_bist[k]), 32'(e_bist));
        check($sformatf("m_en_gen[%0d]", k),   32'(d_gen[k]),  32'(e_gen));
        check($sformatf("m_en_cmp[%0d]", k),   32'(d_cmp[k]),  32'(e_cmp));
        check($sformatf("m_busy[%0d]", k),     32'(d_busy[k]), 32'(m_run[k]));
        check($sformatf("m_done[%0d]", k),     32'(d_done[k]), 32'(m_done[k]));
        check($sformatf("m_pass[%0d]", k),     32'(d_pass[k]), 32'(m_pass[k]));
        check($sformatf("m_fail[%0d]", k),     32'(d_fail[k]), 32'(m_fail[k]));
        check($sformatf("m_sig_cap[%0d]", k),  32'(d_sig[k]),  32'(m_sig[k]));
      end
    end
  end

  // Starts a run (start held for 'hold' cycles) and measures instance k until done.
  task automatic do_run(input int k, input logic [7:0] fsig, input int hold,
                        output int lat_o, output int gen_o, output int cmp_o);
    int n;
    bit got;
    n = 0; got = 0; lat_o = -1; gen_o = 0; cmp_o = 0;
    start = 1'b1;
    while (!got && n < 60) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (n >= hold) start = 1'b0;
      sig_in = (n == NP + lat_of(k) + 2) ? fsig : 8'($urandom);
      if (n == 1) begin
        check("run_bist_rst_first", 32'(d_bist[k]), 32'd1);
        check("run_done_dropped",   32'(d_done[k]), 32'd0);
        check("run_pass_dropped",   32'(d_pass[k]), 32'd0);
      end
      if (k == 1) check("l0_en_cmp_eq_en_gen", 32'(d_cmp[1]), 32'(d_gen[1]));
      if (d_gen[k]) gen_o++;
      if (d_cmp[k]) cmp_o++;
      if (d_done[k]) begin
        got   = 1;
        lat_o = n;
      end
    end
    start = 1'b0;
    check("run_done_within_budget", 32'(got), 32'd1);
  endtask

  initial begin
    int lat, g, c;
    bit saw_done;
    rst = 1'b1; start = 1'b0; abort = 1'b0; sig_in = 8'h00;
    @(posedge clk);
    chk_en = 1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_busy", 32'(d_busy), 32'd0);
    check("reset_done", 32'(d_done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // golden run
    do_run(0, 8'hC0, 1, lat, g, c);
    check("t2_latency", lat, 23);
    check("t2_en_gen_cycles", g, 16);
    check("t2_en_cmp_cycles", c, 16);
    check("t2_pass", 32'(d_pass[0]), 32'd1);
    check("t2_fail", 32'(d_fail[0]), 32'd0);
    check("t2_sig_cap", 32'(d_sig[0]), 32'hC0);
    $display("T2 golden: latency=%0d en_gen=%0d en_cmp=%0d sig_cap=%0h", lat, g, c, d_sig[0]);

    // restart with start held in DONE and while busy
    do_run(0, 8'hC0, 3, lat, g, c);
    check("t5_latency", lat, 23);
    check("t5_en_gen_cycles", g, 16);
    check("t5_en_cmp_cycles", c, 16);
    check("t5_pass", 32'(d_pass[0]), 32'd1);
    $display("T5 restart: latency=%0d en_gen=%0d en_cmp=%0d", lat, g, c);

    // mismatch
    do_run(0, 8'hC1, 1, lat, g, c);
    check("t3_latency", lat, 23);
    check("t3_fail", 32'(d_fail[0]), 32'd1);
    check("t3_pass", 32'(d_pass[0]), 32'd0);
    check("t3_sig_cap", 32'(d_sig[0]), 32'hC1);
    $display("T3 mismatch: fail=%0b sig_cap=%0h", d_fail[0], d_sig[0]);

    // abort in DONE is ignored
    abort = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0;
    check("done_abort_ignored_done", 32'(d_done[0]), 32'd1);
    check("done_abort_ignored_fail", 32'(d_fail[0]), 32'd1);
    $display("abort in DONE: done=%0b fail=%0b", d_done[0], d_fail[0]);

    // abort at RUN count 5, with start also high (abort wins)
    start = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      @(posedge clk); @(negedge clk);
      start = 1'b0;
    end
    check("t4_pre_en_gen", 32'(d_gen[0]), 32'd1);
    abort = 1'b1; start = 1'b1;
    @(posedge clk); @(negedge clk);
    abort = 1'b0; start = 1'b0;
    check("t4_en_gen", 32'(d_gen[0]), 32'd0);
    check("t4_en_cmp", 32'(d_cmp[0]), 32'd0);
    check("t4_busy",   32'(d_busy[0]), 32'd0);
    saw_done = 0;
    repeat (30) begin
      @(negedge clk);
      if (d_done[0]) saw_done = 1;
    end
    check("t4_done_never", 32'(saw_done), 32'd0);
    $display("T4 abort: en_gen=%0b en_cmp=%0b done_seen=%0b", d_gen[0], d_cmp[0], saw_done);
    do_run(0, 8'hC0, 1, lat, g, c);
    check("t4_rerun_latency", lat, 23);
    check("t4_rerun_en_gen", g, 16);
    check("t4_rerun_en_cmp", c, 16);
    check("t4_rerun_pass", 32'(d_pass[0]), 32'd1);
    $display("T4 rerun: latency=%0d en_gen=%0d en_cmp=%0d", lat, g, c);

    // reset mid-RUN
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
    repeat (6) begin @(posedge clk); @(negedge clk); end
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    check("t1_en_gen", 32'(d_gen), 32'd0);
    check("t1_en_cmp", 32'(d_cmp), 32'd0);
    check("t1_busy",   32'(d_busy), 32'd0);
    check("t1_bist",   32'(d_bist), 32'd0);
    repeat (2) begin @(posedge clk); @(negedge clk); end
    rst = 1'b0;
    @(negedge clk);
    $display("T1 reset: busy=%0b en_gen=%0b en_cmp=%0b", d_busy[0], d_gen[0], d_cmp[0]);

    // LATENCY=0 instance
    do_run(1, 8'hC0, 1, lat, g, c);
    check("t6_latency", lat, 19);
    check("t6_en_gen_cycles", g, 16);
    check("t6_en_cmp_cycles", c, 16);
    check("t6_pass", 32'(d_pass[1]), 32'd1);
    check("t6_sig_cap", 32'(d_sig[1]), 32'hC0);
    $display("T6 latency0: latency=%0d en_gen=%0d en_cmp=%0d", lat, g, c);

    repeat (10) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
